dma_xfer_engine: RTL and testbench

DMA_XFER_ENGINE -- requirements
Module: dma_xfer_engine

---
 rtl/dma_xfer_engine.sv | 253 +++++++++++++++++++++++++
 tb/tb_dma_xfer_engine.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_xfer_engine.sv
// Single-channel DMA mover: streams w_count words from a read port into an
// 8-deep FIFO and drains them to a write port, with bus-error and watchdog abort.
module dma_xfer_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [14:0] w_count,
  input  logic        io_mem,
  input  logic [31:0] io_addr,
  input  logic [31:0] mem_addr,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  output logic [31:0] rd_req_addr,
  input  logic        rd_rsp_valid,
  input  logic [31:0] rd_rsp_data,
  input  logic        rd_rsp_err,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_err,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  state,
  output logic [7:0]  fifo_level,
  output logic [31:0] xfer_count,
  output logic [7:0]  err_code,
  output logic [15:0] err_offset
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_XFER  = 4'd1;
  localparam logic [3:0] ST_ERROR = 4'd4;

  localparam logic [7:0] ERR_BUS     = 8'h01;
  localparam logic [7:0] ERR_TIMEOUT = 8'h02;
  localparam logic [7:0] ERR_ALIGN   = 8'h03;

  logic [3:0]  state_r, state_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        done_r, done_nxt_s;
  logic        error_r, error_nxt_s;
  logic        rd_req_valid_r, rd_valid_nxt_s;
  logic        wr_valid_r, wr_valid_nxt_s;
  logic [3:0]  level_r, level_nxt_s;
  logic [3:0]  outstanding_r, out_nxt_s;
  logic [7:0]  wd_r, wd_nxt_s;
  logic [14:0] reads_r, reads_nxt_s;
  logic [14:0] rsp_cnt_r, rsp_nxt_s;
  logic [31:0] xfer_count_r, xfer_nxt_s;
  logic [7:0]  err_code_r, err_code_nxt_s;
  logic [15:0] err_offset_r, err_off_nxt_s;
  logic [14:0] wcnt_r, wcnt_nxt_s;
  logic        io_mem_r;
  logic [31:0] io_addr_r;
  logic [31:0] mem_addr_r;
  logic [2:0]  rd_ptr_r, rd_ptr_nxt_s;
  logic [2:0]  wr_ptr_r, wr_ptr_nxt_s;
  logic [31:0] fifo_mem_r [0:7];

  logic latch_s, push_s, pop_s;
  logic rd_hs_s, wr_hs_s, rsp_take_s, activity_s;

  assign rd_hs_s    = rd_req_valid_r && rd_req_ready;
  assign wr_hs_s    = wr_valid_r && wr_ready;
  // Responses with nothing outstanding are stale (e.g. after reset) and dropped.
  assign rsp_take_s = rd_rsp_valid && (outstanding_r != 4'd0);
  assign activity_s = rd_hs_s || wr_hs_s || rsp_take_s;
  assign wcnt_nxt_s = latch_s ? w_count : wcnt_r;

  assign rd_req_addr = io_mem_r ? io_addr_r : (mem_addr_r + {15'd0, reads_r, 2'b00});
  assign wr_addr     = io_mem_r ? (mem_addr_r + {xfer_count_r[29:0], 2'b00}) : io_addr_r;
  assign wr_data     = fifo_mem_r[rd_ptr_r];

  assign rd_req_valid = rd_req_valid_r;
  assign wr_valid     = wr_valid_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign state        = state_r;
  assign fifo_level   = {4'd0, level_r};
  assign xfer_count   = xfer_count_r;
  assign err_code     = err_code_r;
  assign err_offset   = err_offset_r;

  // Next-state, counter and error bookkeeping for the transfer FSM.
  always_comb begin
    state_nxt_s    = state_r;
    busy_nxt_s     = busy_r;
    done_nxt_s     = 1'b0;
    error_nxt_s    = 1'b0;
    level_nxt_s    = level_r;
    out_nxt_s      = outstanding_r;
    wd_nxt_s       = wd_r;
    reads_nxt_s    = reads_r;
    rsp_nxt_s      = rsp_cnt_r;
    xfer_nxt_s     = xfer_count_r;
    err_code_nxt_s = err_code_r;
    err_off_nxt_s  = err_offset_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    latch_s        = 1'b0;
    push_s         = 1'b0;
    pop_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          latch_s        = 1'b1;
          xfer_nxt_s     = 32'd0;
          err_code_nxt_s = 8'd0;
          err_off_nxt_s  = 16'd0;
          reads_nxt_s    = 15'd0;
          rsp_nxt_s      = 15'd0;
          wd_nxt_s       = 8'd0;
          level_nxt_s    = 4'd0;
          out_nxt_s      = 4'd0;
          rd_ptr_nxt_s   = 3'd0;
          wr_ptr_nxt_s   = 3'd0;
          if (mem_addr[1:0] != 2'b00) begin
            state_nxt_s    = ST_ERROR;
            busy_nxt_s     = 1'b1;
            err_code_nxt_s = ERR_ALIGN;
          end else if (w_count == 15'd0) begin
            done_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_XFER;
            busy_nxt_s  = 1'b1;
          end
        end else begin
          latch_s = 1'b0;
        end
      end
      ST_XFER: begin
        push_s       = rsp_take_s && !rd_rsp_err;
        pop_s        = wr_hs_s;
        reads_nxt_s  = reads_r + {14'd0, rd_hs_s};
        rsp_nxt_s    = rsp_cnt_r + {14'd0, rsp_take_s};
        out_nxt_s    = outstanding_r + {3'd0, rd_hs_s} - {3'd0, rsp_take_s};
        level_nxt_s  = level_r + {3'd0, push_s} - {3'd0, pop_s};
        wr_ptr_nxt_s = wr_ptr_r + {2'd0, push_s};
        rd_ptr_nxt_s = rd_ptr_r + {2'd0, pop_s};
        xfer_nxt_s   = xfer_count_r + {31'd0, wr_hs_s && !wr_err};
        wd_nxt_s     = activity_s ? 8'd0 : ((wd_r == 8'hFF) ? wd_r : (wd_r + 8'd1));
        if ((rsp_take_s && rd_rsp_err) || (wr_hs_s && wr_err)) begin
          state_nxt_s    = ST_ERROR;
          err_code_nxt_s = ERR_BUS;
          err_off_nxt_s  = (rsp_take_s && rd_rsp_err) ? {1'b0, rsp_cnt_r} : xfer_count_r[15:0];
          level_nxt_s    = 4'd0;
          rd_ptr_nxt_s   = 3'd0;
          wr_ptr_nxt_s   = 3'd0;
        end else if ((wd_r == 8'hFF) && !activity_s) begin
          state_nxt_s    = ST_ERROR;
          err_code_nxt_s = ERR_TIMEOUT;
          err_off_nxt_s  = xfer_count_r[15:0];
          level_nxt_s    = 4'd0;
          rd_ptr_nxt_s   = 3'd0;
          wr_ptr_nxt_s   = 3'd0;
        end else if (xfer_nxt_s == {17'd0, wcnt_r}) begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_XFER;
        end
      end
      ST_ERROR: begin
        out_nxt_s    = outstanding_r - {3'd0, rsp_take_s};
        level_nxt_s  = 4'd0;
        rd_ptr_nxt_s = 3'd0;
        wr_ptr_nxt_s = 3'd0;
        wd_nxt_s     = 8'd0;
        if (out_nxt_s == 4'd0) begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
          error_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_ERROR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
        level_nxt_s = 4'd0;
        out_nxt_s   = 4'd0;
      end
    endcase
  end

  // Valids are registered off next-cycle occupancy so the FIFO can never overflow.
  always_comb begin
    rd_valid_nxt_s = (state_nxt_s == ST_XFER) && (reads_nxt_s < wcnt_nxt_s) &&
                     (({1'b0, level_nxt_s} + {1'b0, out_nxt_s}) < 5'd8);
    wr_valid_nxt_s = (state_nxt_s == ST_XFER) && (level_nxt_s != 4'd0);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      rd_req_valid_r <= 1'b0;
      wr_valid_r     <= 1'b0;
      level_r        <= 4'd0;
      outstanding_r  <= 4'd0;
      wd_r           <= 8'd0;
      reads_r        <= 15'd0;
      rsp_cnt_r      <= 15'd0;
      xfer_count_r   <= 32'd0;
      err_code_r     <= 8'd0;
      err_offset_r   <= 16'd0;
      wcnt_r         <= 15'd0;
      io_mem_r       <= 1'b0;
      io_addr_r      <= 32'd0;
      mem_addr_r     <= 32'd0;
      rd_ptr_r       <= 3'd0;
      wr_ptr_r       <= 3'd0;
    end else begin
      state_r        <= state_nxt_s;
      busy_r         <= busy_nxt_s;
      done_r         <= done_nxt_s;
      error_r        <= error_nxt_s;
      rd_req_valid_r <= rd_valid_nxt_s;
      wr_valid_r     <= wr_valid_nxt_s;
      level_r        <= level_nxt_s;
      outstanding_r  <= out_nxt_s;
      wd_r           <= wd_nxt_s;
      reads_r        <= reads_nxt_s;
      rsp_cnt_r      <= rsp_nxt_s;
      xfer_count_r   <= xfer_nxt_s;
      err_code_r     <= err_code_nxt_s;
      err_offset_r   <= err_off_nxt_s;
      wcnt_r         <= wcnt_nxt_s;
      rd_ptr_r       <= rd_ptr_nxt_s;
      wr_ptr_r       <= wr_ptr_nxt_s;
      if (latch_s) begin
        io_mem_r   <= io_mem;
        io_addr_r  <= io_addr;
        mem_addr_r <= mem_addr;
      end
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= rd_rsp_data;
    end
  end

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Directed bench for dma_xfer_engine: a bus model answers reads and a
// scoreboard queue holds expected write address/data pairs.
module tb_dma_xfer_engine;

  logic        clk, rst_n, start, io_mem;
  logic [14:0] w_count;
  logic [31:0] io_addr, mem_addr;
  logic        rd_req_valid, rd_req_ready;
  logic [31:0] rd_req_addr;
  logic        rd_rsp_valid, rd_rsp_err;
  logic [31:0] rd_rsp_data;
  logic        wr_valid, wr_ready, wr_err;
  logic [31:0] wr_addr, wr_data;
  logic        busy, done, error;
  logic [3:0]  state;
  logic [7:0]  fifo_level;
  logic [31:0] xfer_count;
  logic [7:0]  err_code;
  logic [15:0] err_offset;

  int checks = 0;
  int errors = 0;

  bit          rd_ready_en = 1'b1;
  bit          wr_ready_en = 1'b1;
  logic        m_io_mem = 1'b0;
  logic [31:0] m_mem = 32'd0;
  logic [31:0] m_io = 32'd0;
  logic [31:0] salt = 32'h0;
  int          rd_idx = 0, rsp_idx = 0, wexp_idx = 0, err_idx = -1;
  int          rd_hs_total = 0, wr_hs_total = 0;
  logic [31:0] pend[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];

  dma_xfer_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .w_count(w_count), .io_mem(io_mem),
    .io_addr(io_addr), .mem_addr(mem_addr),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .busy(busy), .done(done), .error(error), .state(state),
    .fifo_level(fifo_level), .xfer_count(xfer_count), .err_code(err_code),
    .err_offset(err_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Bus model: one-cycle read latency, data tagged by read index.
  initial begin : bus_model
    logic [31:0] d;
    logic [31:0] exp_ra;
    rd_req_ready = 1'b0; wr_ready = 1'b0; wr_err = 1'b0;
    rd_rsp_valid = 1'b0; rd_rsp_data = 32'd0; rd_rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      rd_rsp_valid = 1'b0; rd_rsp_err = 1'b0; rd_rsp_data = 32'd0;
      if (rst_n && pend.size() != 0) begin
        d = pend.pop_front();
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = d;
        if (rsp_idx == err_idx) begin
          rd_rsp_err = 1'b1;
        end else begin
          exp_data_q.push_back(d);
          exp_addr_q.push_back(m_io_mem ? (m_mem + (32'(wexp_idx) << 2)) : m_io);
          wexp_idx++;
        end
        rsp_idx++;
      end
      rd_req_ready = rd_ready_en;
      wr_ready     = wr_ready_en;
      if (rst_n && rd_req_valid && rd_req_ready) begin
        exp_ra = m_io_mem ? m_io : (m_mem + (32'(rd_idx) << 2));
        chk("rd_addr", rd_req_addr, exp_ra);
        rd_log.push_back(rd_req_addr);
        pend.push_back(salt + {16'hDA7A, 16'(rd_idx)});
        rd_idx++;
        rd_hs_total++;
      end
      if (rst_n && wr_valid && wr_ready) begin
        chk1("wr_expected", exp_data_q.size() != 0, 1'b1);
        if (exp_data_q.size() != 0) begin
          chk("wr_addr", wr_addr, exp_addr_q.pop_front());
          chk("wr_data", wr_data, exp_data_q.pop_front());
        end
        wr_log.push_back(wr_addr);
        wr_hs_total++;
      end
    end
  end

  task automatic do_start(input logic iom, input logic [31:0] ma, input logic [31:0] ia,
                          input logic [14:0] wc);
    m_io_mem = iom; m_mem = ma; m_io = ia;
    rd_idx = 0; rsp_idx = 0; wexp_idx = 0;
    exp_addr_q.delete(); exp_data_q.delete(); rd_log.delete(); wr_log.delete();
    salt = salt + 32'h0101_0000;
    @(negedge clk);
    io_mem = iom; mem_addr = ma; io_addr = ia; w_count = wc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ev(input int max, output bit sd, output bit se, output int cyc);
    sd = 1'b0; se = 1'b0; cyc = max;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done || error) begin
        sd = done; se = error; cyc = i + 1;
        break;
      end
    end
  endtask

  initial begin : global_guard
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stimulus
    bit sd, se;
    int cyc, base_rd, base_wr;
    rst_n = 1'b0; start = 1'b0; io_mem = 1'b0; w_count = 15'd0;
    io_addr = 32'd0; mem_addr = 32'd0;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    chk1("rst_rd_valid", rd_req_valid, 1'b0);
    chk1("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_xfer_count", xfer_count, 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_err_offset", 32'(err_offset), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic MEM->IO transfer on a zero-wait bus.
    do_start(1'b0, 32'h0000_1000, 32'h0000_0040, 15'd4);
    chk1("t1_busy", busy, 1'b1);
    chk("t1_state_xfer", 32'(state), 32'd1);
    wait_ev(100, sd, se, cyc);
    chk1("t1_done_seen", sd, 1'b1);
    chk("t1_state_idle", 32'(state), 32'd0);
    chk1("t1_busy_low", busy, 1'b0);
    chk("t1_xfer_count", xfer_count, 32'd4);
    chk("t1_reads", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4) begin
      chk("t1_rd0", rd_log[0], 32'h0000_1000);
      chk("t1_rd3", rd_log[3], 32'h0000_100C);
    end
    chk("t1_writes", 32'(wr_log.size()), 32'd4);
    if (wr_log.size() != 0) chk("t1_wr_io", wr_log[0], 32'h0000_0040);
    @(negedge clk);
    chk1("t1_done_pulse", done, 1'b0);

    // Zero-length request.
    base_rd = rd_hs_total;
    do_start(1'b0, 32'h0000_2000, 32'h0000_0040, 15'd0);
    chk1("t0_done", done, 1'b1);
    chk1("t0_busy", busy, 1'b0);
    chk("t0_state", 32'(state), 32'd0);
    @(negedge clk);
    chk1("t0_done_pulse", done, 1'b0);
    chk("t0_no_reads", 32'(rd_hs_total - base_rd), 32'd0);

    // Backpressure: FIFO fills, reads stall, nothing lost.
    wr_ready_en = 1'b0;
    do_start(1'b0, 32'h0000_4000, 32'h0000_0080, 15'd20);
    repeat (30) @(negedge clk);
    chk("t2_fifo_full", 32'(fifo_level), 32'd8);
    chk1("t2_rd_valid_low", rd_req_valid, 1'b0);
    wr_ready_en = 1'b1;
    wait_ev(200, sd, se, cyc);
    chk1("t2_done_seen", sd, 1'b1);
    chk("t2_xfer_count", xfer_count, 32'd20);
    chk("t2_sb_empty", 32'(exp_data_q.size()), 32'd0);

    // Misaligned MEM base.
    base_rd = rd_hs_total; base_wr = wr_hs_total;
    do_start(1'b0, 32'h0000_1002, 32'h0000_0040, 15'd4);
    wait_ev(20, sd, se, cyc);
    chk1("t3_error_seen", se, 1'b1);
    chk("t3_err_code", 32'(err_code), 32'h03);
    chk("t3_err_offset", 32'(err_offset), 32'd0);
    chk("t3_state", 32'(state), 32'd0);
    chk("t3_no_bus", 32'((rd_hs_total - base_rd) + (wr_hs_total - base_wr)), 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_err_hold", 32'(err_code), 32'h03);

    // Read error on word 5.
    err_idx = 5;
    do_start(1'b0, 32'h0000_5000, 32'h0000_0040, 15'd10);
    chk("t4_err_cleared", 32'(err_code), 32'd0);
    wait_ev(100, sd, se, cyc);
    chk1("t4_error_seen", se, 1'b1);
    chk("t4_err_code", 32'(err_code), 32'h01);
    chk("t4_err_offset", 32'(err_offset), 32'd5);
    chk("t4_drained", 32'(pend.size()), 32'd0);
    chk1("t4_xfer_le5", xfer_count <= 32'd5, 1'b1);
    chk("t4_fifo_flushed", 32'(fifo_level), 32'd0);
    err_idx = -1;

    // Watchdog with the read port stuck.
    rd_ready_en = 1'b0;
    do_start(1'b0, 32'h0000_6000, 32'h0000_0040, 15'd3);
    wait_ev(400, sd, se, cyc);
    chk1("t5_error_seen", se, 1'b1);
    chk1("t5_latency", (cyc >= 255) && (cyc <= 270), 1'b1);
    chk("t5_err_code", 32'(err_code), 32'h02);
    chk("t5_err_offset", 32'(err_offset), 32'd0);
    rd_ready_en = 1'b1;

    // IO->MEM with address wrap; a second start while busy is ignored.
    do_start(1'b1, 32'hFFFF_FFFC, 32'h0000_0100, 15'd2);
    io_mem = 1'b0; mem_addr = 32'h0000_7000; w_count = 15'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ev(100, sd, se, cyc);
    chk1("t6_done_seen", sd, 1'b1);
    chk("t6_xfer_count", xfer_count, 32'd2);
    chk("t6_writes", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("t6_wr0", wr_log[0], 32'hFFFF_FFFC);
      chk("t6_wr1", wr_log[1], 32'h0000_0000);
    end
    if (rd_log.size() != 0) chk("t6_rd_io", rd_log[0], 32'h0000_0100);
    repeat (5) @(negedge clk);
    chk1("t6_ignored_busy", busy, 1'b0);
    chk("t6_ignored_reads", 32'(rd_log.size()), 32'd2);

    // Reset in the middle of a transfer.
    wr_ready_en = 1'b0;
    do_start(1'b0, 32'h0000_8000, 32'h0000_0040, 15'd20);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_state", 32'(state), 32'd0);
    chk("t7_fifo", 32'(fifo_level), 32'd0);
    chk1("t7_rd_valid", rd_req_valid, 1'b0);
    chk1("t7_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_ready_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("t7_idle_after", 32'(state), 32'd0);
    chk("t7_fifo_after", 32'(fifo_level), 32'd0);
    chk("t7_xfer_after", xfer_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
